// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD<->binary converters: FSM states, digit width
// and the per-digit correction constants for both conversion directions.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;
  // Reverse double-dabble (BCD -> binary): digits >= 8 lose 3 after each shift.
  localparam logic [BCD_DIGIT_W-1:0] CORR_THRESH   = 4'd8;
  localparam logic [BCD_DIGIT_W-1:0] CORR_VALUE    = 4'd3;
  // Forward double-dabble (binary -> BCD): digits >= 5 gain 3 before each shift.
  localparam logic [BCD_DIGIT_W-1:0] ADD_THRESH    = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADD_VALUE     = 4'd3;

  function automatic logic digit_ok(input logic [BCD_DIGIT_W-1:0] d);
    return d <= BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_to_binary_big_if.sv
// Request/result bundle of the BCD-to-binary converter.
// Handshake: start is sampled on a rising edge only while busy=0 (also in the
// done cycle); done is a one-cycle pulse with binary_value/error valid and held.
interface bcd_to_binary_big_if #(
  parameter int BIN_W = 16
);
  import bcd_pkg::*;

  logic             start;
  logic [3:0]       thousands;
  logic [3:0]       hundreds;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic             busy;
  logic             done;
  logic             error;
  logic [BIN_W-1:0] binary_value;
  state_t           dbg_state;

  modport master (
    output start, thousands, hundreds, tens, ones,
    input  busy, done, error, binary_value, dbg_state
  );

  modport slave (
    input  start, thousands, hundreds, tens, ones,
    output busy, done, error, binary_value, dbg_state
  );

endinterface

// File: rtl/bcd_digit_correct.sv
// One BCD digit of the reverse double-dabble correction: d >= 8 ? d-3 : d.
module bcd_digit_correct
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= CORR_THRESH) ? (digit_i - CORR_VALUE) : digit_i;

endmodule

// File: rtl/bcd_to_binary_big.sv
// Sequential 4-digit packed BCD to binary converter (reverse double-dabble),
// one shift/correct iteration per cycle, one conversion in flight.
module bcd_to_binary_big
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_to_binary_big_if.slave   bus
);

  localparam int BCD_W = DIGITS * BCD_DIGIT_W;
  localparam int TOT_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);

  if (DIGITS != 4) begin : g_bad_digits
    $error("bcd_to_binary_big: DIGITS must be 4");
  end
  if (BIN_W < 14) begin : g_bad_width
    $error("bcd_to_binary_big: BIN_W must be >= 14 to hold 9999");
  end

  state_t           state_q, state_d;
  logic [TOT_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             err_q, err_d;

  logic [TOT_W-1:0] shifted;
  logic [BCD_W-1:0] corrected;
  logic [BCD_W-1:0] in_bcd;
  logic             in_valid;

  // The BCD LSB falls into the binary MSB; correction acts on the shifted value.
  assign shifted = {1'b0, sr_q[TOT_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_correct u_corr (
      .digit_i (shifted[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (corrected[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign in_bcd   = {bus.thousands, bus.hundreds, bus.tens, bus.ones};
  assign in_valid = digit_ok(bus.thousands) && digit_ok(bus.hundreds) &&
                    digit_ok(bus.tens) && digit_ok(bus.ones);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      SHIFT: begin
        sr_d  = {corrected, shifted[BIN_W-1:0]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = DONE;
          bin_d   = shifted[BIN_W-1:0];
          err_d   = 1'b0;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request, giving back-to-back issue.
        state_d = IDLE;
        if (bus.start) begin
          if (in_valid) begin
            state_d = SHIFT;
            sr_d    = {in_bcd, {BIN_W{1'b0}}};
            cnt_d   = '0;
          end else begin
            state_d = DONE;
            bin_d   = '0;
            err_d   = 1'b1;
          end
        end
      end
    endcase
  end

  assign bus.busy         = (state_q == SHIFT);
  assign bus.done         = (state_q == DONE);
  assign bus.error        = err_q;
  assign bus.binary_value = bin_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: doc/bcd_to_binary_big.md
Name: bcd_to_binary_big

Overview:
Sequential converter from 4-digit packed BCD (thousands/hundreds/tens/ones) to a 16-bit unsigned binary value, using reverse double-dabble.
- Each iteration shifts the combined BCD:binary register right one bit, then subtracts 3 from every BCD digit that is >= 8.
- Provides the inverse path of the existing binary-to-BCD display converter, so 7-segment/keypad digit entry can set PWM width and compare values.
- Start/busy/done handshake, one conversion in flight.

Parameters:
BIN_W, 16, binary output width; also the iteration count (must be >= 14 to hold 9999).
DIGITS, 4, number of BCD digits; fixed at 4 for this revision, checked by elaboration assertion.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
start  in  1  request conversion; sampled only when busy=0.
thousands  in  4  BCD digit, weight 1000.
hundreds  in  4  BCD digit, weight 100.
tens  in  4  BCD digit, weight 10.
ones  in  4  BCD digit, weight 1.
busy  out  1  conversion in progress.
done  out  1  one-cycle pulse: binary_value/error updated this cycle.
error  out  1  last request contained a digit > 9; held until next done.
binary_value  out  16  result of last conversion; held until next done.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, busy=0, done=0, error=0, binary_value=0, iteration counter=0, shift register=0. Reset overrides everything, including mid-conversion; the in-flight conversion is discarded and no done is issued.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 and all digits <= 9: latch {thousands,hundreds,tens,ones} into the BCD half of a 16+BIN_W bit register, clear the binary half and counter, go to SHIFT.
  - If start=1 and any digit > 9: go to DONE with error=1 and binary_value forced to 0.
  - Digits are sampled only at the start edge; later input changes are ignored.
- SHIFT: each cycle:
  - Shift the full register right by 1; the BCD LSB enters the binary MSB.
  - Per digit (combinational on the shifted value): if digit >= 8, subtract 3 (4-bit, no borrow across digits).
  - Register the result; counter++.
  - After BIN_W iterations (counter == BIN_W-1 at the edge), go to DONE.
- DONE (single cycle):
  - Entered by registering binary_value = binary half (error=0), or the error case above; done=1 for exactly this cycle.
  - Return to IDLE next edge.
  - busy=0 in DONE, so start is accepted in the DONE cycle and begins a new conversion (back-to-back).
- busy=1 exactly while state==SHIFT. start while busy=1 is ignored, with no queueing.
- Latency, valid input: start sampled at edge k, done high in the cycle following edge k+BIN_W (17 cycles from the start cycle for BIN_W=16). Throughput: one conversion per BIN_W+1 cycles.
- Latency, invalid input: done high in the cycle after the start edge.
- Result range 0..9999; upper BIN_W-14 bits of binary_value are always 0 for valid input.
- binary_value and error change only at the DONE transition.

Decomposition:
- Shared package bcd_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - BCD_DIGIT_W=4, BCD_MAX_DIGIT=9, CORR_THRESH=8, CORR_VALUE=3;
  - the same package is reused by the binary-to-BCD side (ADD_THRESH=5, ADD_VALUE=3).
- One sub-module, bcd_digit_correct: purely combinational 4-bit in/out, implementing digit >= 8 ? digit-3 : digit. It is instantiated DIGITS times.

Test Plan:
- Reset, then start with digits 9,9,9,9 -> done exactly 17 cycles after the start cycle; binary_value=16'd9999 (0x270F), error=0; busy high the 16 cycles before done.
- Digits 1,2,3,4, then 0,0,0,0, then 0,0,0,1 -> 0x04D2, 0x0000, 0x0001 respectively; all conversions with the same latency.
- Digits 0,0,10(0xA),5 with start -> done on next cycle, error=1, binary_value=0, busy never asserts. A following valid 0,0,4,2 -> 42 with error=0.
- Start pulses with 5,5,5,5 while busy, mid-conversion -> ignored; the only result is from the original request. Start asserted in the done cycle with 0,8,0,8 -> accepted, result 808 after a further 17 cycles.
- rst_n=0 for one cycle at iteration 7 of a 6,5,5,3 conversion -> no done pulse; busy=0, binary_value=0, error=0 next cycle. A fresh conversion afterwards gives 6553 correctly.
- Inputs change every cycle during SHIFT after start sampled 3,0,0,0 -> result 3000, unaffected.
